// File: rtl/kernel_ring_store.sv
// Banked ring store: per-block lane rings loaded beat by beat, then rotated in lockstep.
// Optional rotation counter enabled by defining KERNEL_RING_STORE_ROT_CNT_EN.
module kernel_ring_store #(
  parameter int DATA_WIDTH = 16,
  parameter int NB_BLOCKS  = 12,
  parameter int ROWS       = 3,
  parameter int DEPTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 load_valid_in,
  output logic                                 load_ready_out,
  input  logic [5:0]                           load_block_in,
  input  logic [ROWS*DATA_WIDTH-1:0]           load_data_in,
  input  logic                                 cycle_in,
  input  logic                                 clear_in,
  output logic [NB_BLOCKS*ROWS*DATA_WIDTH-1:0] data_out,
  output logic [1:0]                           state_out,
  output logic                                 idx_err_out,
  output logic [7:0]                           rot_cnt_out,
  output logic                                 rot_wrap_out
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              FW   = $clog2(DEPTH + 1);
  localparam logic [FW-1:0]   FULL = FW'(DEPTH);
  localparam logic [6:0]      NB7  = 7'(NB_BLOCKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t                r_state;
  logic [FW-1:0]         r_fill [NB_BLOCKS];
  logic [PW-1:0]         r_wptr [NB_BLOCKS];
  logic [PW-1:0]         r_rptr [NB_BLOCKS];
  logic                  r_idx_err;
  logic [DATA_WIDTH-1:0] r_mem  [NB_BLOCKS][ROWS][DEPTH];

  logic                  w_idx_ok;
  logic                  w_accept;
  logic                  w_wr_en;
  logic                  w_all_full;
  logic                  w_rot;
  logic [NB_BLOCKS-1:0]  w_blk_hit;
  logic [FW-1:0]         w_sel_fill;

  // Block decode by comparison avoids indexing the block arrays with an out-of-range index.
  always_comb begin
    w_idx_ok   = ({1'b0, load_block_in} < NB7);
    w_sel_fill = '0;
    w_blk_hit  = '0;
    w_all_full = 1'b1;
    for (int b = 0; b < NB_BLOCKS; b++) begin
      w_blk_hit[b] = (load_block_in == 6'(b));
      if (w_blk_hit[b]) w_sel_fill = r_fill[b];
      if (r_fill[b] != FULL) w_all_full = 1'b0;
    end
  end

  assign load_ready_out = (r_state != S_READY) && (!w_idx_ok || (w_sel_fill < FULL));
  assign w_accept       = load_valid_in && load_ready_out;
  assign w_wr_en        = w_accept && w_idx_ok && !clear_in && !rst_in;
  assign w_rot          = (r_state == S_READY) && cycle_in && !clear_in;

  always_ff @(posedge clk) begin
    if (rst_in || clear_in) begin
      r_state   <= S_IDLE;
      r_idx_err <= 1'b0;
      for (int b = 0; b < NB_BLOCKS; b++) begin
        r_fill[b] <= '0;
        r_wptr[b] <= '0;
        r_rptr[b] <= '0;
      end
    end else begin
      if (w_accept && !w_idx_ok) r_idx_err <= 1'b1;
      for (int b = 0; b < NB_BLOCKS; b++) begin
        if (w_wr_en && w_blk_hit[b]) begin
          r_wptr[b] <= r_wptr[b] + PW'(1);
          r_fill[b] <= r_fill[b] + FW'(1);
        end
        if (w_rot) r_rptr[b] <= r_rptr[b] + PW'(1);
      end
      case (r_state)
        S_IDLE:    if (w_accept && w_idx_ok) r_state <= S_LOADING;
        S_LOADING: if (w_all_full) r_state <= S_READY;
        default:   r_state <= S_READY;
      endcase
    end
  end

  // Storage is never reset; empty blocks are masked on the output instead.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB_BLOCKS; b++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_wr_en && w_blk_hit[b])
          r_mem[b][r][r_wptr[b]] <= load_data_in[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int b = 0; b < NB_BLOCKS; b++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r_fill[b] != '0)
          data_out[(b*ROWS+r)*DATA_WIDTH +: DATA_WIDTH] = r_mem[b][r][r_rptr[b]];
      end
    end
  end

  assign state_out   = r_state;
  assign idx_err_out = r_idx_err;

`ifdef KERNEL_RING_STORE_ROT_CNT_EN
  logic [7:0] r_rot_cnt;
  logic       r_rot_wrap;

  always_ff @(posedge clk) begin
    if (rst_in || clear_in) begin
      r_rot_cnt  <= '0;
      r_rot_wrap <= 1'b0;
    end else begin
      r_rot_wrap <= 1'b0;
      if (w_rot) begin
        if (r_rot_cnt == 8'(DEPTH - 1)) begin
          r_rot_cnt  <= '0;
          r_rot_wrap <= 1'b1;
        end else begin
          r_rot_cnt  <= r_rot_cnt + 8'd1;
        end
      end
    end
  end

  assign rot_cnt_out  = r_rot_cnt;
  assign rot_wrap_out = r_rot_wrap;
`else
  assign rot_cnt_out  = '0;
  assign rot_wrap_out = 1'b0;
`endif

endmodule

// File: doc/kernel_ring_store.md
KERNEL_RING_STORE -- requirements
Module: kernel_ring_store

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one stored word.
REQ-002 SHALL have parameter NB_BLOCKS, default 12, number of independent ring blocks (1..64).
REQ-003 SHALL have parameter ROWS, default 3, words written per load beat and per-block output lanes (1..8).
REQ-004 SHALL have parameter DEPTH, default 8, entries per lane ring (power of two, 2..256).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port load_valid_in  input  1  load beat offered.
REQ-008 SHALL have port load_ready_out  output  1  load beat accepted when high with load_valid_in.
REQ-009 SHALL have port load_block_in  input  6  target block index for the beat.
REQ-010 SHALL have port load_data_in  input  ROWS*DATA_WIDTH  lane r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port cycle_in  input  1  rotate all rings one position.
REQ-012 SHALL have port clear_in  input  1  discard contents, return to IDLE.
REQ-013 SHALL have port data_out  output  NB_BLOCKS*ROWS*DATA_WIDTH  head word of block b lane r at index (b*ROWS+r).
REQ-014 SHALL have port state_out  output  2  IDLE=0, LOADING=1, READY=2.
REQ-015 SHALL have port idx_err_out  output  1  sticky out-of-range block index flag.
REQ-016 SHALL have port rot_cnt_out  output  8  rotations modulo DEPTH.
REQ-017 SHALL have port rot_wrap_out  output  1  one-cycle pulse when rot_cnt returns to 0.

Function
REQ-018 SHALL keep per-block fill count 0..DEPTH and per-block write and read pointers modulo DEPTH.
REQ-019 SHALL drive load_ready_out high iff state!=READY and (load_block_in>=NB_BLOCKS or fill[load_block_in]<DEPTH).
REQ-020 SHALL, on accepted beat with valid index, write all ROWS lanes at write pointer of that block, increment pointer and fill.
REQ-021 SHALL, on accepted beat with index>=NB_BLOCKS, drop data and set idx_err_out until reset or clear_in.
REQ-022 SHALL transition IDLE->LOADING on first valid accepted beat; LOADING->READY in the cycle after every block's fill equals DEPTH.
REQ-023 SHALL, in READY with cycle_in high, advance every block's read pointer by one (mod DEPTH); data_out shows new head the next cycle.
REQ-024 SHALL ignore cycle_in outside READY; rot_cnt unchanged.
REQ-025 SHALL present data_out registered-pointer heads; before a block's first write its lanes read 0.
REQ-026 SHALL, on clear_in, zero fills, pointers, rot_cnt, idx_err_out and enter IDLE next cycle; clear_in overrides simultaneous load and cycle.
REQ-027 SHALL keep storage unchanged on clear_in; data_out lanes of unwritten blocks read 0 via fill==0 masking.
REQ-028 SHALL hold load_ready_out low in READY; load and cycle are therefore never both effective.

Reset
REQ-029 SHALL, while rst_in high at clk edge, set state IDLE, all fills/pointers 0, rot_cnt_out 0, rot_wrap_out 0, idx_err_out 0, load_ready_out 1, data_out 0.
REQ-030 SHALL abort any in-progress load or rotation on reset; no partial write committed in the reset cycle.

Configuration
REQ-031 SHALL, with macro KERNEL_RING_STORE_ROT_CNT_EN defined, increment rot_cnt_out per effective rotation mod DEPTH and pulse rot_wrap_out on the rotation returning it to 0.
REQ-032 SHALL, without KERNEL_RING_STORE_ROT_CNT_EN, tie rot_cnt_out and rot_wrap_out to 0 and instantiate no counter.

Verification
REQ-033 SHALL cover full load: defaults, 8 beats per block with lane value b*100+k -> state READY one cycle after 96th beat, data_out block 5 lane 0 = 500.
REQ-034 SHALL cover wrap: 8 cycle_in pulses in READY -> heads return to initial values, rot_wrap_out pulses once (with macro), rot_cnt 0.
REQ-035 SHALL cover backpressure: 9th beat to block 2 during LOADING -> load_ready_out 0, fill stays 8, no overwrite.
REQ-036 SHALL cover bad index: beat to block 12 -> accepted, idx_err_out 1, no block fill changes.
REQ-037 SHALL cover clear during cycle: clear_in and cycle_in same cycle -> state IDLE, rot_cnt 0, data_out 0.
REQ-038 SHALL cover reset mid-load: rst_in after 40 beats -> all outputs at reset values, fresh load completes normally.
